bypass_network: RTL
===================

BYPASS_NETWORK -- requirements
Module: bypass_network

Interface
REQ-001 SHALL have parameter DATA_W, default 16, forwarded datum width.
REQ-002 SHALL have parameter REG_AW, default 3, register index width.
REQ-003 SHALL have parameter EXE_DEPTH, default 2, ALU-result history entries (min 1).
REQ-004 SHALL have parameter MEM_DEPTH, default 1, load-result history entries (min 1).
REQ-005 SHALL have parameter NRD, default 4, lookup ports (e.g. sr1, sr2, mdr, mar).
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-007 SHALL have ports: stall_all  in  1  freeze all history; flush  in  1  squash this cycle's captures.
REQ-008 SHALL have ports: alu_v  in  1  ALU result writes regfile; alu_dest  in  REG_AW; alu_data  in  DATA_W.
REQ-009 SHALL have ports: ld_v  in  1  load result writes regfile; ld_dest  in  REG_AW; ld_data  in  DATA_W.
REQ-010 SHALL have ports: ld_issue_v  in  1  load now in execute; ld_issue_dest  in  REG_AW.
REQ-011 SHALL have ports: rd_en  in  NRD; rd_reg  in  NRD x REG_AW; rd_hit  out  NRD; rd_data  out  NRD x DATA_W.
REQ-012 SHALL have ports: hazard  out  1  load-use stall request; hit_cnt  out  16  forwarded-lookup count.

Function
REQ-013 SHALL keep two shift chains: EXE entries e[0..EXE_DEPTH-1], MEM entries m[0..MEM_DEPTH-1]; each entry = {v, dest, data}; index 0 youngest.
REQ-014 SHALL, each clk edge with stall_all=0, shift both chains by one, oldest entry discarded.
REQ-015 SHALL load e[0] with {alu_v & ~flush, alu_dest, alu_data} and m[0] with {ld_v & ~flush, ld_dest, ld_data}.
REQ-016 SHALL hold every entry and hit_cnt unchanged while stall_all=1, flush included.
REQ-017 SHALL, per port p, compute rd_hit[p] combinationally = rd_en[p] & any valid entry with dest==rd_reg[p].
REQ-018 SHALL select youngest match: lowest index within a chain; across chains e[k] beats m[j] iff k<=j.
REQ-019 SHALL drive rd_data[p]=selected entry data on hit and all-zeros on miss (never X).
REQ-020 SHALL return the same result on all ports requesting one register in one cycle.
REQ-021 SHALL assert hazard combinationally when ld_issue_v=1 and any rd_en[p]=1 with rd_reg[p]==ld_issue_dest.
REQ-022 SHALL force rd_hit[p]=0 for every port raising hazard in that cycle.
REQ-023 SHALL add popcount(rd_hit) to hit_cnt on each non-stalled edge, saturating at 16'hFFFF.
REQ-024 SHALL retain the older entry when a register is rewritten; priority alone resolves it.
REQ-025 SHALL add zero latency on lookup: capture at edge N visible at N+1.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear all v bits, dest and data fields, and hit_cnt.
REQ-027 SHALL therefore drive rd_hit=0, rd_data=0, hazard per REQ-021 (inputs only), hit_cnt=0 during reset.
REQ-028 SHALL discard any in-flight history on mid-operation reset; first post-reset edge captures normally.

Structure
REQ-029 SHALL place typedef fwd_entry_t {v, dest, data} and default widths in shared package lc3b_types.
REQ-030 SHALL use one sub-module fwd_lookup (one port's priority match and select), instantiated NRD times.
REQ-031 SHALL hold the chain shifting, hazard and hit_cnt logic in bypass_network itself.

Verification
REQ-032 SHALL cover: alu_v=1, dest=3, data=16'h1234, edge; rd_reg[0]=3 -> rd_hit[0]=1, rd_data[0]=16'h1234.
REQ-033 SHALL cover: R3=16'h0001 then R3=16'h0002 on consecutive edges -> lookup returns 16'h0002; after EXE_DEPTH+1 idle edges -> miss, data 0.
REQ-034 SHALL cover: e[1] holds R5=16'hAAAA, m[1] holds R5=16'hBBBB -> 16'hAAAA; e[1] and m[0] -> 16'hBBBB.
REQ-035 SHALL cover: ld_issue_v=1, dest=2, rd_reg[1]=2 -> hazard=1, rd_hit[1]=0; ld_issue_dest=4 -> hazard=0.
REQ-036 SHALL cover: stall_all=1 for 3 edges with alu_v=1 -> entries and hit_cnt unchanged; flush=1 capture -> no hit next cycle.
REQ-037 SHALL cover: rst_n low mid-stream -> all rd_hit=0, hit_cnt=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/bypass_network_pkg.sv
// Shared LC-3b forwarding types: default widths and the history entry layout
// used by the bypass network and its lookup slices.
package lc3b_types;

   localparam int DATA_W_DEF    = 16;
   localparam int REG_AW_DEF    = 3;
   localparam int EXE_DEPTH_DEF = 2;
   localparam int MEM_DEPTH_DEF = 1;
   localparam int NRD_DEF       = 4;
   localparam int HIT_CNT_W     = 16;

   typedef struct packed {
      logic                  v;
      logic [REG_AW_DEF-1:0] dest;
      logic [DATA_W_DEF-1:0] data;
   } fwd_entry_t;

endpackage

// File: rtl/bypass_network_if.sv
// Signal bundle between the pipeline (master) and the bypass network (slave).
// Lookup ports are purely combinational: rd_en/rd_reg in, rd_hit/rd_data out in the same cycle.
interface bypass_network_if
   import lc3b_types::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int NRD    = NRD_DEF
) ();

   logic                           stall_all;
   logic                           flush;
   logic                           alu_v;
   logic [REG_AW-1:0]              alu_dest;
   logic [DATA_W-1:0]              alu_data;
   logic                           ld_v;
   logic [REG_AW-1:0]              ld_dest;
   logic [DATA_W-1:0]              ld_data;
   logic                           ld_issue_v;
   logic [REG_AW-1:0]              ld_issue_dest;
   logic [NRD-1:0]                 rd_en;
   logic [NRD-1:0][REG_AW-1:0]     rd_reg;
   logic [NRD-1:0]                 rd_hit;
   logic [NRD-1:0][DATA_W-1:0]     rd_data;
   logic                           hazard;
   logic [HIT_CNT_W-1:0]           hit_cnt;

   modport master (
      output stall_all, flush, alu_v, alu_dest, alu_data, ld_v, ld_dest, ld_data,
             ld_issue_v, ld_issue_dest, rd_en, rd_reg,
      input  rd_hit, rd_data, hazard, hit_cnt
   );

   modport slave (
      input  stall_all, flush, alu_v, alu_dest, alu_data, ld_v, ld_dest, ld_data,
             ld_issue_v, ld_issue_dest, rd_en, rd_reg,
      output rd_hit, rd_data, hazard, hit_cnt
   );

endinterface

// File: rtl/bypass_network_lookup.sv
// One lookup port: finds the youngest valid history entry for a register.
// EXE entry k wins over MEM entry j when k <= j; misses return zero data.
module fwd_lookup
   import lc3b_types::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int REG_AW    = REG_AW_DEF,
   parameter int EXE_DEPTH = EXE_DEPTH_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic                              i_rd_en,
   input  logic [REG_AW-1:0]                 i_rd_reg,
   input  logic [EXE_DEPTH-1:0]              i_e_v,
   input  logic [EXE_DEPTH-1:0][REG_AW-1:0]  i_e_dest,
   input  logic [EXE_DEPTH-1:0][DATA_W-1:0]  i_e_data,
   input  logic [MEM_DEPTH-1:0]              i_m_v,
   input  logic [MEM_DEPTH-1:0][REG_AW-1:0]  i_m_dest,
   input  logic [MEM_DEPTH-1:0][DATA_W-1:0]  i_m_data,
   output logic                              o_hit,
   output logic [DATA_W-1:0]                 o_data
);

   logic              w_e_hit;
   logic              w_m_hit;
   int                w_e_idx;
   int                w_m_idx;
   logic [DATA_W-1:0] w_e_data;
   logic [DATA_W-1:0] w_m_data;

   // Scan oldest to youngest so the last match written is the youngest one.
   always_comb begin
      w_e_hit  = 1'b0;
      w_e_idx  = 0;
      w_e_data = '0;
      for (int k = EXE_DEPTH - 1; k >= 0; k--) begin
         if (i_e_v[k] && (i_e_dest[k] == i_rd_reg)) begin
            w_e_hit  = 1'b1;
            w_e_idx  = k;
            w_e_data = i_e_data[k];
         end
      end
      w_m_hit  = 1'b0;
      w_m_idx  = 0;
      w_m_data = '0;
      for (int j = MEM_DEPTH - 1; j >= 0; j--) begin
         if (i_m_v[j] && (i_m_dest[j] == i_rd_reg)) begin
            w_m_hit  = 1'b1;
            w_m_idx  = j;
            w_m_data = i_m_data[j];
         end
      end
   end

   always_comb begin
      o_hit  = i_rd_en & (w_e_hit | w_m_hit);
      o_data = '0;
      if (i_rd_en) begin
         if (w_e_hit && (!w_m_hit || (w_e_idx <= w_m_idx))) begin
            o_data = w_e_data;
         end else if (w_m_hit) begin
            o_data = w_m_data;
         end
      end
   end

endmodule

// File: rtl/bypass_network.sv
// Result-forwarding network: ALU and load result history chains, per-port
// lookup slices, load-use hazard detection and a saturating forwarded-hit counter.
module bypass_network
   import lc3b_types::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int REG_AW    = REG_AW_DEF,
   parameter int EXE_DEPTH = EXE_DEPTH_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF,
   parameter int NRD       = NRD_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   bypass_network_if.slave  bus
);

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] dest;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t                          r_e [EXE_DEPTH];
   entry_t                          r_m [MEM_DEPTH];
   logic [HIT_CNT_W-1:0]            r_hit_cnt;

   logic [EXE_DEPTH-1:0]            w_e_v;
   logic [EXE_DEPTH-1:0][REG_AW-1:0] w_e_dest;
   logic [EXE_DEPTH-1:0][DATA_W-1:0] w_e_data;
   logic [MEM_DEPTH-1:0]            w_m_v;
   logic [MEM_DEPTH-1:0][REG_AW-1:0] w_m_dest;
   logic [MEM_DEPTH-1:0][DATA_W-1:0] w_m_data;
   logic [NRD-1:0]                  w_haz;
   logic [NRD-1:0]                  w_rd_en_eff;
   logic [NRD-1:0]                  w_rd_hit;
   logic [NRD-1:0][DATA_W-1:0]      w_rd_data;
   logic [HIT_CNT_W:0]              w_hit_pop;
   logic [HIT_CNT_W:0]              w_hit_sum;
   logic [HIT_CNT_W-1:0]            w_hit_cnt_nxt;

   for (genvar k = 0; k < EXE_DEPTH; k++) begin : g_e_flat
      assign w_e_v[k]    = r_e[k].v;
      assign w_e_dest[k] = r_e[k].dest;
      assign w_e_data[k] = r_e[k].data;
   end

   for (genvar j = 0; j < MEM_DEPTH; j++) begin : g_m_flat
      assign w_m_v[j]    = r_m[j].v;
      assign w_m_dest[j] = r_m[j].dest;
      assign w_m_data[j] = r_m[j].data;
   end

   // A port that trips the load-use hazard must not forward stale data.
   for (genvar p = 0; p < NRD; p++) begin : g_port
      assign w_haz[p] = bus.ld_issue_v & bus.rd_en[p] & (bus.rd_reg[p] == bus.ld_issue_dest);
      assign w_rd_en_eff[p] = bus.rd_en[p] & ~w_haz[p];

      fwd_lookup #(
         .DATA_W    (DATA_W),
         .REG_AW    (REG_AW),
         .EXE_DEPTH (EXE_DEPTH),
         .MEM_DEPTH (MEM_DEPTH)
      ) u_lookup (
         .i_rd_en   (w_rd_en_eff[p]),
         .i_rd_reg  (bus.rd_reg[p]),
         .i_e_v     (w_e_v),
         .i_e_dest  (w_e_dest),
         .i_e_data  (w_e_data),
         .i_m_v     (w_m_v),
         .i_m_dest  (w_m_dest),
         .i_m_data  (w_m_data),
         .o_hit     (w_rd_hit[p]),
         .o_data    (w_rd_data[p])
      );
   end

   always_comb begin
      w_hit_pop = '0;
      for (int p = 0; p < NRD; p++) begin
         w_hit_pop = w_hit_pop + (HIT_CNT_W+1)'(w_rd_hit[p]);
      end
      w_hit_sum     = {1'b0, r_hit_cnt} + w_hit_pop;
      w_hit_cnt_nxt = w_hit_sum[HIT_CNT_W] ? {HIT_CNT_W{1'b1}} : w_hit_sum[HIT_CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < EXE_DEPTH; k++) r_e[k] <= '0;
         for (int j = 0; j < MEM_DEPTH; j++) r_m[j] <= '0;
         r_hit_cnt <= '0;
      end else if (!bus.stall_all) begin
         r_e[0] <= '{v: bus.alu_v & ~bus.flush, dest: bus.alu_dest, data: bus.alu_data};
         for (int k = 1; k < EXE_DEPTH; k++) r_e[k] <= r_e[k-1];
         r_m[0] <= '{v: bus.ld_v & ~bus.flush, dest: bus.ld_dest, data: bus.ld_data};
         for (int j = 1; j < MEM_DEPTH; j++) r_m[j] <= r_m[j-1];
         r_hit_cnt <= w_hit_cnt_nxt;
      end
   end

   assign bus.rd_hit  = w_rd_hit;
   assign bus.rd_data = w_rd_data;
   assign bus.hazard  = |w_haz;
   assign bus.hit_cnt = r_hit_cnt;

endmodule
